// File: rtl/title_pixel_fetcher.sv
// title_pixel_fetcher
//
// Purpose: streams the 8-bit-per-pixel title image from SRAM to the colour
// mapper. Each 16-bit SRAM word holds two pixels: the low byte is the even
// DrawX pixel and the high byte is the odd DrawX pixel. Words are prefetched
// ahead of the raster into a small FIFO, so SRAM latency and arbitration
// stalls are hidden during active video.
//
// Optional build macro: TITLE_HALF_RES_EN
//   Defined:   the source image is H_ACTIVE/2 x V_ACTIVE/2 and each source
//              pixel is shown 2x2. Each source line is fetched twice.
//   Undefined: full-resolution image, one word per output pixel pair.
//
// Ports:
//   Clk          in   system clock
//   Reset        in   synchronous, active-low reset
//   enable       in   title screen shown; low forces IDLE and flushes
//   frame_start  in   one-cycle pulse in vertical blank, before line 0
//   pix_en       in   one-cycle pulse per pixel advance
//   DrawX/DrawY  in   current raster column/row (10 bits each)
//   sram_req     out  read request
//   sram_addr    out  read word address (ADDR_W bits)
//   sram_gnt     in   request accepted this cycle
//   sram_rvalid  in   read data valid (in order, latency >= 1)
//   sram_rdata   in   read data (16 bits)
//   Color_Idx    out  current pixel-pair word, 0 while the FIFO is empty
//   underrun     out  sticky: a pixel was consumed with the FIFO empty
module title_pixel_fetcher #(
  parameter int                H_ACTIVE   = 640,
  parameter int                V_ACTIVE   = 480,
  parameter int                ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_gnt,
  input  logic              sram_rvalid,
  input  logic [15:0]       sram_rdata,
  output logic [15:0]       Color_Idx,
  output logic              underrun
);

`ifdef TITLE_HALF_RES_EN
  localparam int WORDS_PER_LINE = H_ACTIVE / 4;
  localparam int COL_W          = $clog2(WORDS_PER_LINE);
`else
  localparam int WORDS_PER_LINE = H_ACTIVE / 2;
`endif
  // Half-res counts every output line, so each source line is counted twice.
  localparam int TOTAL_WORDS = WORDS_PER_LINE * V_ACTIVE;
  localparam int GCNT_W      = $clog2(TOTAL_WORDS + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int LVL_W       = CNT_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [10:0]      H_LIM     = 11'(H_ACTIVE);
  localparam logic [10:0]      V_LIM     = 11'(V_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_outstanding;
  logic [CNT_W-1:0]    r_discard;
  logic [CNT_W-1:0]    w_out_next;
  logic [GCNT_W-1:0]   r_gcnt;
  logic                r_underrun;
  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
`ifdef TITLE_HALF_RES_EN
  logic [COL_W-1:0]    r_fetch_col;
  logic                r_fetch_pass;
  logic [7:0]          w_byte;
`endif

  logic              w_grant;
  logic              w_flush;
  logic              w_active;
  logic              w_slot;
  logic              w_pop_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_empty;
  logic              w_last_grant;
  logic [LVL_W-1:0]  w_level;
  logic [15:0]       w_head;

  assign w_grant  = sram_req & sram_gnt;
  // Dropping enable keeps the block flushed every cycle it stays low.
  assign w_flush  = ~enable | frame_start;
  assign w_active = ({1'b0, DrawX} < H_LIM) && ({1'b0, DrawY} < V_LIM);
`ifdef TITLE_HALF_RES_EN
  assign w_slot   = pix_en & w_active & (DrawX[1:0] == 2'b11);
`else
  assign w_slot   = pix_en & w_active & DrawX[0];
`endif
  assign w_pop_req    = w_slot & (r_state != S_IDLE) & ~w_flush;
  assign w_empty      = (r_count == '0);
  assign w_pop        = w_pop_req & ~w_empty;
  // Responses requested before the last flush are dropped, not buffered.
  assign w_drop       = sram_rvalid & (r_discard != '0);
  assign w_push       = sram_rvalid & ~w_drop & ~w_flush;
  assign w_level      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_last_grant = w_grant && (r_gcnt == GCNT_W'(TOTAL_WORDS - 1));
  assign w_head       = r_mem[r_rd_ptr];
  assign sram_addr    = r_addr;
  assign underrun     = r_underrun;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_grant && !sram_rvalid) begin
      w_out_next = r_outstanding + 1'b1;
    end else if (!w_grant && sram_rvalid) begin
      w_out_next = r_outstanding - 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = S_IDLE;
    end else if (frame_start) begin
      w_state_next = S_FILL;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_last_grant) begin
            w_state_next = S_DONE;
          end else if (w_pop_req) begin
            w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (w_last_grant) begin
            w_state_next = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs. In-flight reads count against FIFO space so a response
  // can never arrive with the FIFO full.
  always_comb begin
    sram_req = 1'b0;
    if ((r_state == S_FILL || r_state == S_RUN) && (w_level < DEPTH_LVL)) begin
      sram_req = 1'b1;
    end
  end

  // Address generation and in-flight bookkeeping
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_addr        <= BASE_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_gcnt        <= '0;
`ifdef TITLE_HALF_RES_EN
      r_fetch_col   <= '0;
      r_fetch_pass  <= 1'b0;
`endif
    end else begin
      r_outstanding <= w_out_next;
      if (w_flush) begin
        // Everything still in flight after this edge belongs to the old frame.
        r_addr       <= BASE_ADDR;
        r_discard    <= w_out_next;
        r_gcnt       <= '0;
`ifdef TITLE_HALF_RES_EN
        r_fetch_col  <= '0;
        r_fetch_pass <= 1'b0;
`endif
      end else begin
        if (w_drop) begin
          r_discard <= r_discard - 1'b1;
        end
        if (w_grant) begin
          r_gcnt <= r_gcnt + 1'b1;
`ifdef TITLE_HALF_RES_EN
          // After the first pass over a source line, rewind to its start so
          // the odd output line re-reads the same words.
          if (r_fetch_col == COL_W'(WORDS_PER_LINE - 1)) begin
            r_fetch_col  <= '0;
            r_fetch_pass <= ~r_fetch_pass;
            if (r_fetch_pass) begin
              r_addr <= r_addr + 1'b1;
            end else begin
              r_addr <= r_addr - ADDR_W'(WORDS_PER_LINE - 1);
            end
          end else begin
            r_fetch_col <= r_fetch_col + 1'b1;
            r_addr      <= r_addr + 1'b1;
          end
`else
          r_addr <= r_addr + 1'b1;
`endif
        end
      end
    end
  end

  // Word FIFO storage
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sram_rdata;
    end
  end

  // FIFO pointers, occupancy and underrun flag
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_pop_req && w_empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

  // Pixel output
`ifdef TITLE_HALF_RES_EN
  assign w_byte = DrawX[1] ? w_head[15:8] : w_head[7:0];
  always_comb begin
    Color_Idx = 16'h0000;
    if (!w_empty) begin
      Color_Idx = {w_byte, w_byte};
    end
  end
`else
  always_comb begin
    Color_Idx = 16'h0000;
    if (!w_empty) begin
      Color_Idx = w_head;
    end
  end
`endif

endmodule

// File: tb/tb_title_pixel_fetcher.sv
// Directed testbench for title_pixel_fetcher. A short frame (V_ACTIVE=16)
// keeps the full-frame run small; SRAM word n holds n (word 0 holds 0xBBAA
// in the half-resolution build). The SRAM model grants every request while
// sram_gnt is high and answers two clocks after the grant.
module tb_title_pixel_fetcher;
  localparam int H     = 640;
  localparam int V     = 16;
  localparam int TOTAL = (H / 2) * V;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        enable;
  logic        frame_start;
  logic        pix_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        sram_req;
  logic [19:0] sram_addr;
  logic        sram_gnt;
  logic        sram_rvalid;
  logic [15:0] sram_rdata;
  logic [15:0] Color_Idx;
  logic        underrun;

  int n_checks = 0;
  int n_pass   = 0;

  title_pixel_fetcher #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(20), .BASE_ADDR(20'h00000), .FIFO_DEPTH(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .frame_start(frame_start),
    .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY), .sram_req(sram_req),
    .sram_addr(sram_addr), .sram_gnt(sram_gnt), .sram_rvalid(sram_rvalid),
    .sram_rdata(sram_rdata), .Color_Idx(Color_Idx), .underrun(underrun)
  );

  always #10 Clk = ~Clk;

  function automatic logic [15:0] mem_data(input logic [19:0] a);
`ifdef TITLE_HALF_RES_EN
    if (a == 20'd0) return 16'hBBAA;
`endif
    return a[15:0];
  endfunction

  // SRAM model: samples the request just before each rising edge.
  logic        s0_v = 1'b0;
  logic        s1_v = 1'b0;
  logic [19:0] s0_a = '0;
  logic [19:0] s1_a = '0;
  int          grant_cnt = 0;
  logic [19:0] grant_log [$];

  initial begin
    sram_rvalid = 1'b0;
    sram_rdata  = 16'h0000;
    forever begin
      @(negedge Clk);
      sram_rvalid = s1_v;
      sram_rdata  = s1_v ? mem_data(s1_a) : 16'h0000;
      s1_v = s0_v;
      s1_a = s0_a;
      s0_v = sram_req & sram_gnt;
      s0_a = sram_addr;
      if (s0_v) begin
        grant_cnt++;
        grant_log.push_back(sram_addr);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic advance;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input logic pe);
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_en = pe;
    @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b0; enable = 1'b1; frame_start = 1'b0; sram_gnt = 1'b1;
    DrawX = 10'd0; DrawY = 10'd480; pix_en = 1'b0;
    advance;
    advance;
    @(negedge Clk);
    n_checks++; if (sram_req !== 1'b0) $display("FAIL reset_req: got %b want 0", sram_req); else n_pass++;
    n_checks++; if (sram_addr !== 20'h0) $display("FAIL reset_addr: got %h want 00000", sram_addr); else n_pass++;
    n_checks++; if (Color_Idx !== 16'h0) $display("FAIL reset_color: got %h want 0000", Color_Idx); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    advance;
    Reset = 1'b1;
    advance;
  endtask

  task automatic test_fill;
    grant_log.delete();
    frame_start = 1'b1;
    advance;
    frame_start = 1'b0;
    @(negedge Clk);
    n_checks++; if (sram_req !== 1'b1) $display("FAIL fill_req_rise: got %b want 1", sram_req); else n_pass++;
    n_checks++; if (sram_addr !== 20'h0) $display("FAIL fill_first_addr: got %h want 00000", sram_addr); else n_pass++;
    repeat (10) advance;
    @(negedge Clk);
    n_checks++; if (grant_log.size() != 4) $display("FAIL fill_grants: got %0d want 4", grant_log.size()); else n_pass++;
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      n_checks++; if (grant_log[i] !== 20'(i)) $display("FAIL fill_addr%0d: got %h want %h", i, grant_log[i], 20'(i)); else n_pass++;
    end
    n_checks++; if (sram_req !== 1'b0) $display("FAIL fill_req_drop: got %b want 0", sram_req); else n_pass++;
    n_checks++; if (sram_addr !== 20'd4) $display("FAIL fill_addr_next: got %h want 00004", sram_addr); else n_pass++;
    advance;
  endtask

  task automatic test_line0;
    logic [15:0] exp_c;
    for (int x = 0; x < H; x++) begin
      drive(x, 0, 1'b1);
      exp_c = 16'(x / 2);
      n_checks++; if (Color_Idx !== exp_c) $display("FAIL line0_color x=%0d: got %h want %h", x, Color_Idx, exp_c); else n_pass++;
      advance;
    end
    DrawX = 10'd640; pix_en = 1'b0;
    @(negedge Clk);
    n_checks++; if (underrun !== 1'b0) $display("FAIL line0_underrun: got %b want 0", underrun); else n_pass++;
    repeat (4) advance;
  endtask

  // Line 1 runs normally up to x=99, then grants stop for 20 pixels. At x=100
  // words 370,371 are buffered and 372 is in flight; request 373 is waiting.
  task automatic test_stall;
    logic [15:0] exp_c;
    for (int x = 0; x < 120; x++) begin
      if (x == 100) sram_gnt = 1'b0;
      drive(x, 1, 1'b1);
      exp_c = (x < 106) ? 16'(320 + x / 2) : 16'h0000;
      n_checks++; if (Color_Idx !== exp_c) $display("FAIL stall_color x=%0d: got %h want %h", x, Color_Idx, exp_c); else n_pass++;
      if (x >= 100) begin
        n_checks++; if (sram_addr !== 20'd373) $display("FAIL stall_addr x=%0d: got %h want 00175", x, sram_addr); else n_pass++;
        n_checks++; if (underrun !== (x >= 108)) $display("FAIL stall_underrun x=%0d: got %b want %b", x, underrun, (x >= 108)); else n_pass++;
      end
      advance;
    end
  endtask

  // Two reads (373, 374) are in flight when frame_start arrives.
  task automatic test_flush;
    logic [15:0] exp_c;
    DrawX = 10'd0; DrawY = 10'd480; pix_en = 1'b0; sram_gnt = 1'b1;
    advance;
    advance;
    frame_start = 1'b1; sram_gnt = 1'b0;
    grant_log.delete();
    advance;
    frame_start = 1'b0; sram_gnt = 1'b1;
    @(negedge Clk);
    n_checks++; if (sram_addr !== 20'h0) $display("FAIL flush_addr: got %h want 00000", sram_addr); else n_pass++;
    n_checks++; if (sram_req !== 1'b1) $display("FAIL flush_req: got %b want 1", sram_req); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL flush_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (Color_Idx !== 16'h0) $display("FAIL flush_color: got %h want 0000", Color_Idx); else n_pass++;
    repeat (10) advance;
    @(negedge Clk);
    n_checks++; if (grant_log.size() != 4) $display("FAIL flush_grants: got %0d want 4", grant_log.size()); else n_pass++;
    if (grant_log.size() > 0) begin
      n_checks++; if (grant_log[0] !== 20'h0) $display("FAIL flush_first_grant: got %h want 00000", grant_log[0]); else n_pass++;
    end
    n_checks++; if (sram_addr !== 20'd4) $display("FAIL flush_addr_next: got %h want 00004", sram_addr); else n_pass++;
    advance;
    for (int x = 0; x < 4; x++) begin
      drive(x, 0, 1'b1);
      exp_c = 16'(x / 2);
      n_checks++; if (Color_Idx !== exp_c) $display("FAIL flush_stale x=%0d: got %h want %h", x, Color_Idx, exp_c); else n_pass++;
      advance;
    end
    DrawY = 10'd480; pix_en = 1'b0;
  endtask

  task automatic test_full_frame;
    logic [15:0] exp_c;
    frame_start = 1'b1; sram_gnt = 1'b0;
    grant_cnt = 0;
    grant_log.delete();
    advance;
    frame_start = 1'b0; sram_gnt = 1'b1;
    repeat (12) advance;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        drive(x, y, 1'b1);
        if (x % 2 == 0) begin
          exp_c = 16'(y * 320 + x / 2);
          n_checks++; if (Color_Idx !== exp_c) $display("FAIL frame_color y=%0d x=%0d: got %h want %h", y, x, Color_Idx, exp_c); else n_pass++;
        end
        advance;
      end
      DrawX = 10'd640; pix_en = 1'b0;
      repeat (4) advance;
    end
    DrawY = 10'd480;
    repeat (10) advance;
    @(negedge Clk);
    n_checks++; if (grant_cnt != TOTAL) $display("FAIL frame_grants: got %0d want %0d", grant_cnt, TOTAL); else n_pass++;
    if (grant_log.size() > 0) begin
      n_checks++; if (grant_log[grant_log.size()-1] !== 20'(TOTAL - 1)) $display("FAIL frame_last_addr: got %h want %h", grant_log[grant_log.size()-1], 20'(TOTAL - 1)); else n_pass++;
    end
    n_checks++; if (sram_req !== 1'b0) $display("FAIL done_req: got %b want 0", sram_req); else n_pass++;
    n_checks++; if (sram_addr !== 20'(TOTAL)) $display("FAIL done_addr: got %h want %h", sram_addr, 20'(TOTAL)); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL frame_underrun: got %b want 0", underrun); else n_pass++;
    n_checks++; if (Color_Idx !== 16'h0) $display("FAIL done_color: got %h want 0000", Color_Idx); else n_pass++;
    repeat (5) advance;
    @(negedge Clk);
    n_checks++; if (sram_req !== 1'b0) $display("FAIL done_req_hold: got %b want 0", sram_req); else n_pass++;
    advance;
  endtask

  task automatic test_restart_and_disable;
    frame_start = 1'b1;
    advance;
    frame_start = 1'b0;
    @(negedge Clk);
    n_checks++; if (sram_req !== 1'b1) $display("FAIL restart_req: got %b want 1", sram_req); else n_pass++;
    n_checks++; if (sram_addr !== 20'h0) $display("FAIL restart_addr: got %h want 00000", sram_addr); else n_pass++;
    advance;
    enable = 1'b0;
    advance;
    @(negedge Clk);
    n_checks++; if (sram_req !== 1'b0) $display("FAIL idle_req: got %b want 0", sram_req); else n_pass++;
    n_checks++; if (sram_addr !== 20'h0) $display("FAIL idle_addr: got %h want 00000", sram_addr); else n_pass++;
    n_checks++; if (Color_Idx !== 16'h0) $display("FAIL idle_color: got %h want 0000", Color_Idx); else n_pass++;
    advance;
    enable = 1'b1;
    repeat (3) advance;
    @(negedge Clk);
    n_checks++; if (sram_req !== 1'b0) $display("FAIL idle_hold_req: got %b want 0", sram_req); else n_pass++;
    advance;
  endtask

`ifdef TITLE_HALF_RES_EN
  task automatic test_half_res;
    logic [15:0] d;
    logic [7:0]  b;
    logic [9:0]  xv;
    logic [15:0] exp_c;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < H; x++) begin
        drive(x, y, 1'b1);
        xv = 10'(x);
        d = mem_data(20'(x / 4));
        b = xv[1] ? d[15:8] : d[7:0];
        exp_c = {b, b};
        n_checks++; if (Color_Idx !== exp_c) $display("FAIL half_color y=%0d x=%0d: got %h want %h", y, x, Color_Idx, exp_c); else n_pass++;
        advance;
      end
      DrawX = 10'd640; pix_en = 1'b0;
      repeat (4) advance;
    end
    n_checks++; if (grant_log.size() < 320) $display("FAIL half_grants: got %0d want >=320", grant_log.size()); else n_pass++;
    if (grant_log.size() >= 320) begin
      for (int i = 0; i < 320; i++) begin
        n_checks++; if (grant_log[i] !== 20'(i % 160)) $display("FAIL half_addr%0d: got %h want %h", i, grant_log[i], 20'(i % 160)); else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_fill;
`ifdef TITLE_HALF_RES_EN
    test_half_res;
`else
    test_line0;
    test_stall;
    test_flush;
    test_full_frame;
    test_restart_and_disable;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
